// File: rtl/spi_frame_slave.sv
// SPI frame slave: oversampled CPHA=0 peripheral moving one frame per select window.
// Streams received words as they complete and snapshots the tx frame at select.
module spi_frame_slave #(
    parameter int FRAME_BITS = 1024,
    parameter int WORD_BITS  = 16,
    parameter int CPOL       = 0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    sck,
    input  logic                                    cs_n,
    input  logic                                    sdi,
    output logic                                    sdo,
    output logic                                    sdo_oe,
    input  logic [FRAME_BITS-1:0]                   tx_frame,
    output logic [FRAME_BITS-1:0]                   rx_frame,
    output logic                                    rx_valid,
    output logic [WORD_BITS-1:0]                    rx_word,
    output logic                                    rx_word_valid,
    output logic [$clog2(FRAME_BITS/WORD_BITS)-1:0] rx_word_idx,
    output logic                                    frame_err,
    output logic                                    busy
);

    localparam int IW  = $clog2(FRAME_BITS / WORD_BITS);
    localparam int CW  = $clog2(FRAME_BITS + 1);
    localparam int WBW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic SCK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                state, state_nx;
    logic [2:0]            sck_q;
    logic [1:0]            cs_q;
    logic [1:0]            sdi_q;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [CW-1:0]         bitcnt;
    logic [WBW-1:0]        wbit;
    logic [IW-1:0]         widx;
    logic                  word_pend;
    logic                  frame_pend;
    logic                  sck_rise, sck_fall;
    logic                  sample, shift;
    logic                  cs_hi, sdi_s;

    // Synchronisers idle at the bus idle levels so reset release is quiet
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_q <= {3{SCK_IDLE}};
            cs_q  <= 2'b11;
            sdi_q <= 2'b00;
        end else begin
            sck_q <= {sck_q[1:0], sck};
            cs_q  <= {cs_q[0], cs_n};
            sdi_q <= {sdi_q[0], sdi};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign sample   = SCK_IDLE ? sck_fall : sck_rise;
    assign shift    = SCK_IDLE ? sck_rise : sck_fall;
    assign cs_hi    = cs_q[1];
    assign sdi_s    = sdi_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!cs_hi) state_nx = ACTIVE;
            ACTIVE:  begin
                if (frame_pend) state_nx = DONE;
                else if (cs_hi) state_nx = IDLE;
            end
            DONE:    if (cs_hi) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sdo    = 1'b0;
        sdo_oe = 1'b0;
        busy   = 1'b0;
        unique case (state)
            ACTIVE: begin
                sdo    = tx_shift[FRAME_BITS-1];
                sdo_oe = 1'b1;
                busy   = 1'b1;
            end
            DONE: begin
                sdo_oe = 1'b1;
                busy   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_shift      <= '0;
            rx_shift      <= '0;
            bitcnt        <= '0;
            wbit          <= '0;
            widx          <= '0;
            word_pend     <= 1'b0;
            frame_pend    <= 1'b0;
            rx_frame      <= '0;
            rx_valid      <= 1'b0;
            rx_word       <= '0;
            rx_word_valid <= 1'b0;
            rx_word_idx   <= '0;
            frame_err     <= 1'b0;
        end else begin
            rx_valid      <= 1'b0;
            rx_word_valid <= 1'b0;
            frame_err     <= 1'b0;
            word_pend     <= 1'b0;
            frame_pend    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cs_hi) begin
                        tx_shift <= tx_frame;
                        bitcnt   <= '0;
                        wbit     <= '0;
                        widx     <= '0;
                    end
                end
                ACTIVE: begin
                    if (sample && !frame_pend &&
                        bitcnt != CW'(FRAME_BITS)) begin
                        rx_shift   <= {rx_shift[FRAME_BITS-2:0], sdi_s};
                        bitcnt     <= bitcnt + CW'(1);
                        word_pend  <= (wbit == WBW'(WORD_BITS - 1));
                        frame_pend <= (bitcnt == CW'(FRAME_BITS - 1));
                        wbit       <= (wbit == WBW'(WORD_BITS - 1)) ?
                                      '0 : wbit + WBW'(1);
                    end
                    if (shift)
                        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                    if (word_pend) begin
                        rx_word       <= rx_shift[WORD_BITS-1:0];
                        rx_word_valid <= 1'b1;
                        rx_word_idx   <= widx;
                        widx          <= widx + IW'(1);
                    end
                    // A completing frame wins over a simultaneous deselect
                    if (frame_pend) begin
                        rx_frame <= rx_shift;
                        rx_valid <= 1'b1;
                    end else if (cs_hi && bitcnt != '0) begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: CPOL=0 and CPOL=1 instances on mirrored sck,
// checked against a transaction-level model of words, frames and errors.
module tb_spi_frame_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck0, sck1, cs_n, sdi;
    logic [31:0] tx_frame;

    logic        sdo0, oe0, rxv0, rxwv0, fe0, busy0;
    logic [31:0] rxf0;
    logic [7:0]  rxw0;
    logic [1:0]  idx0;
    logic        sdo1, oe1, rxv1, rxwv1, fe1, busy1;
    logic [31:0] rxf1;
    logic [7:0]  rxw1;
    logic [1:0]  idx1;

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_w[$];
    logic [1:0]  exp_i[$];
    logic [31:0] exp_f[$];
    int          nerr = 0;
    int          rpw[2], rpf[2], rpe[2];
    logic [7:0]  mw[2];
    logic [1:0]  mi[2];
    logic [31:0] mf[2];

    always #5 clk = ~clk;

    spi_frame_slave #(.FRAME_BITS(32), .WORD_BITS(8), .CPOL(0)) dut0 (
        .clk(clk), .reset(rst_n), .sck(sck0), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo0), .sdo_oe(oe0), .tx_frame(tx_frame), .rx_frame(rxf0),
        .rx_valid(rxv0), .rx_word(rxw0), .rx_word_valid(rxwv0),
        .rx_word_idx(idx0), .frame_err(fe0), .busy(busy0)
    );

    spi_frame_slave #(.FRAME_BITS(32), .WORD_BITS(8), .CPOL(1)) dut1 (
        .clk(clk), .reset(rst_n), .sck(sck1), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo1), .sdo_oe(oe1), .tx_frame(tx_frame), .rx_frame(rxf1),
        .rx_valid(rxv1), .rx_word(rxw1), .rx_word_valid(rxwv1),
        .rx_word_idx(idx1), .frame_err(fe1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%h req=%h", nm, a, e);
        end
    endtask

    task automatic cmp(input int d, input logic wv, input logic [7:0] w,
                       input logic [1:0] wi, input logic fv, input logic [31:0] f,
                       input logic fe, input logic oe, input logic bz);
        if (wv) begin
            if (rpw[d] < exp_w.size()) begin
                mw[d] = exp_w[rpw[d]];
                mi[d] = exp_i[rpw[d]];
                rpw[d]++;
            end else begin
                checks++; failures++;
                $display("FAIL unexpected_word dut%0d act=%h req=none", d, w);
            end
        end
        chk($sformatf("rx_word dut%0d", d), 32'(w), 32'(mw[d]));
        chk($sformatf("rx_word_idx dut%0d", d), 32'(wi), 32'(mi[d]));
        if (fv) begin
            if (rpf[d] < exp_f.size()) begin
                mf[d] = exp_f[rpf[d]];
                rpf[d]++;
            end else begin
                checks++; failures++;
                $display("FAIL unexpected_rx_valid dut%0d act=%h req=none", d, f);
            end
        end
        chk($sformatf("rx_frame dut%0d", d), f, mf[d]);
        if (fe) begin
            if (rpe[d] < nerr) rpe[d]++;
            else begin
                checks++; failures++;
                $display("FAIL unexpected_frame_err dut%0d act=1 req=0", d);
            end
        end
        chk($sformatf("sdo_oe_vs_busy dut%0d", d), 32'(oe), 32'(bz));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp(0, rxwv0, rxw0, idx0, rxv0, rxf0, fe0, oe0, busy0);
            cmp(1, rxwv1, rxw1, idx1, rxv1, rxf1, fe1, oe1, busy1);
        end
    end

    task automatic chk_drained();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("words_seen dut%0d", d), 32'(rpw[d]), 32'(exp_w.size()));
            chk($sformatf("frames_seen dut%0d", d), 32'(rpf[d]), 32'(exp_f.size()));
            chk($sformatf("errs_seen dut%0d", d), 32'(rpe[d]), 32'(nerr));
        end
    endtask

    task automatic xfer(input logic [31:0] tx, input logic [31:0] mosi,
                        input int nbits, input int chg, input logic [31:0] tx2,
                        input bit keep, output logic [31:0] got0,
                        output logic [31:0] got1);
        int nw;
        logic [31:0] snap;
        logic eb;
        nw = ((nbits > 32) ? 32 : nbits) / 8;
        for (int k = 0; k < nw; k++) begin
            exp_w.push_back(mosi[31-8*k -: 8]);
            exp_i.push_back(2'(k));
        end
        if (!keep) begin
            if (nbits >= 32) exp_f.push_back(mosi);
            else if (nbits > 0) nerr++;
        end
        tx_frame = tx;
        snap = tx;
        got0 = '0;
        got1 = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("oe_early dut0", 32'(oe0), 32'd0);
        chk("oe_early dut1", 32'(oe1), 32'd0);
        @(posedge clk);
        #1;
        chk("oe_first dut0", 32'(oe0), 32'd1);
        chk("sdo_first dut0", 32'(sdo0), 32'(snap[31]));
        chk("sdo_first dut1", 32'(sdo1), 32'(snap[31]));
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg) tx_frame = tx2;
            sdi = (i < 32) ? mosi[31-i] : 1'($urandom);
            #40;
            sck0 = 1'b1;
            sck1 = 1'b0;
            eb = (i < 32) ? snap[31-i] : 1'b0;
            chk($sformatf("sdo bit%0d dut0", i), 32'(sdo0), 32'(eb));
            chk($sformatf("sdo bit%0d dut1", i), 32'(sdo1), 32'(eb));
            if (i < 32) begin
                got0[31-i] = sdo0;
                got1[31-i] = sdo1;
            end
            #40;
            sck0 = 1'b0;
            sck1 = 1'b1;
        end
        #40;
        if (!keep) begin
            cs_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk("busy_hold dut0", 32'(busy0), 32'd1);
            chk("busy_hold dut1", 32'(busy1), 32'd1);
            @(posedge clk);
            #1;
            chk("busy_fall dut0", 32'(busy0), 32'd0);
            chk("busy_fall dut1", 32'(busy1), 32'd0);
            repeat (6) @(negedge clk);
            chk_drained();
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g0, g1;
        int nb;
        rst_n = 1'b0;
        cs_n = 1'b1;
        sck0 = 1'b0;
        sck1 = 1'b1;
        sdi = 1'b0;
        tx_frame = '0;
        for (int d = 0; d < 2; d++) begin
            rpw[d] = 0; rpf[d] = 0; rpe[d] = 0;
            mw[d] = '0; mi[d] = '0; mf[d] = '0;
        end
        repeat (5) @(negedge clk);
        chk("reset rx_frame", rxf0, 32'd0);
        chk("reset busy", 32'({busy0, oe0, busy1, oe1}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset mid-frame after 13 sample edges
        xfer(32'h5A5A_0000, 32'hC3A5_1234, 13, -1, 0, 1'b1, g0, g1);
        chk_drained();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst ctl0", 32'({sdo0, oe0, rxv0, rxwv0, fe0, busy0, idx0}), 32'd0);
        chk("mid_rst ctl1", 32'({sdo1, oe1, rxv1, rxwv1, fe1, busy1, idx1}), 32'd0);
        chk("mid_rst rx_word0", 32'(rxw0), 32'd0);
        chk("mid_rst rx_word1", 32'(rxw1), 32'd0);
        cs_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mw[d] = '0; mi[d] = '0; mf[d] = '0;
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        xfer(32'h0, 32'h0BAD_F00D, 32, -1, 0, 1'b0, g0, g1);
        chk("post_rst rx_frame0", rxf0, 32'h0BAD_F00D);

        // Nominal transfer
        xfer(32'hA5C3_0F81, 32'h1234_5678, 32, -1, 0, 1'b0, g0, g1);
        chk("t2 sdo stream0", g0, 32'hA5C3_0F81);
        chk("t2 sdo stream1", g1, 32'hA5C3_0F81);
        chk("t2 rx_frame0", rxf0, 32'h1234_5678);
        chk("t2 last word0", 32'({idx0, rxw0}), 32'h378);

        // tx_frame changes mid-frame: snapshot must hold
        xfer(32'hA5C3_0F81, 32'h1234_5678, 32, 5, 32'hFFFF_FFFF, 1'b0, g0, g1);
        chk("t3 snapshot0", g0, 32'hA5C3_0F81);
        xfer(tx_frame, 32'h1234_5678, 32, -1, 0, 1'b0, g0, g1);
        chk("t3 next frame0", g0, 32'hFFFF_FFFF);

        // Short frame
        xfer($urandom, 32'hDEAD_BEEF, 20, -1, 0, 1'b0, g0, g1);
        chk("t4 rx_frame kept0", rxf0, 32'h1234_5678);
        chk("t4 last word0", 32'({idx0, rxw0}), 32'h1AD);

        // Over-long select window
        xfer($urandom, 32'hCAFE_BABE, 40, -1, 0, 1'b0, g0, g1);
        chk("t5 rx_frame0", rxf0, 32'hCAFE_BABE);

        // CPOL=1 instance
        xfer($urandom, 32'h0000_00FF, 32, -1, 0, 1'b0, g0, g1);
        chk("t6 rx_frame1", rxf1, 32'h0000_00FF);

        for (int r = 0; r < 30; r++) begin
            case ($urandom_range(0, 9))
                5, 6, 7: nb = $urandom_range(1, 31);
                8:       nb = $urandom_range(33, 40);
                9:       nb = 0;
                default: nb = 32;
            endcase
            xfer($urandom, $urandom, nb, -1, 0, 1'b0, g0, g1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_frame_slave.md
Name: spi_frame_slave

Overview:
- Parametrised SPI peripheral that moves one FRAME_BITS-wide frame per chip-select window between the MCU and the FFT datapath.
- Runs entirely in the FPGA system clock domain and oversamples sck, cs_n and sdi.
- Adds per-word streaming, tx snapshotting, short-frame detection and selectable clock polarity.
- Sits between the MCU SPI pins and the FFT input/output buffers.

Parameters:
FRAME_BITS  1024  bits per frame; must be a multiple of WORD_BITS
WORD_BITS   16    bits per streamed word (one FFT sample)
CPOL        0     idle level of sck; 0 or 1 (CPHA fixed at 0)

Ports:
clk            input   1                system clock
reset          input   1                asynchronous, active-low reset
sck            input   1                SPI clock from MCU, asynchronous to clk
cs_n           input   1                SPI chip select, active low, asynchronous
sdi            input   1                COPI data
sdo            output  1                CIPO data
sdo_oe         output  1                high while selected; pad tri-state enable
tx_frame       input   FRAME_BITS       FFT result to transmit, MSB first
rx_frame       output  FRAME_BITS       last complete received frame
rx_valid       output  1                1-clk pulse when rx_frame updates
rx_word        output  WORD_BITS        most recent complete word
rx_word_valid  output  1                1-clk pulse per completed word
rx_word_idx    output  clog2(FRAME_BITS/WORD_BITS)  index of rx_word within the frame
frame_err      output  1                1-clk pulse when a frame is aborted short
busy           output  1                high in ACTIVE or DONE

Behaviour:
- Input synchronisation:
  - sck, cs_n and sdi each pass through 2-FF synchronisers.
  - A third sck stage drives edge detection.
  - clk must be at least 4x the sck frequency.
- Edge strobes (one clk each, CPHA=0):
  - Sample edge is the leading edge: rising if CPOL=0, falling if CPOL=1.
  - Shift edge is the trailing edge.
- Reset (reset low, asynchronous): all outputs 0 immediately, state IDLE, all counters and shift registers 0.
- FSM states:
  - IDLE:
    - sdo=0, sdo_oe=0.
    - On synced cs_n falling: tx_shift<=tx_frame (snapshot; later tx_frame changes are ignored), bitcnt<=0, word index<=0, go to ACTIVE.
  - ACTIVE:
    - sdo=tx_shift[MSB], sdo_oe=1.
    - Sample strobe: rx_shift<={rx_shift, sdi_sync}, bitcnt++.
    - Shift strobe: tx_shift<<=1, zero-filled.
    - Word completion: when bitcnt reaches a multiple of WORD_BITS, on the next clk rx_word<=low WORD_BITS of rx_shift, rx_word_valid=1, rx_word_idx=the completed word's index, then the word index increments.
    - Frame completion: when bitcnt reaches FRAME_BITS, on the next clk rx_frame<=rx_shift, rx_valid=1, and the state goes to DONE. The final word pulse and rx_valid coincide.
    - Synced cs_n high with 0<bitcnt<FRAME_BITS: frame_err pulses for 1 clk, rx_frame is unchanged, no rx_valid, go to IDLE. Words already streamed stay valid.
    - Synced cs_n high with bitcnt=0: go to IDLE, no error.
  - DONE:
    - sdo=0, sdo_oe=1.
    - Further sck edges are ignored (no shifting, no pulses).
    - Synced cs_n high: go to IDLE.
- First-bit timing:
  - tx_frame[FRAME_BITS-1] appears on sdo 3 clk after the physical cs_n fall.
  - The MCU guarantees at least 4 clk between the cs_n fall and the first sck edge.
- Back-to-back frames: cs_n must stay high at least 3 clk between frames. A new cs_n fall resnapshots tx_frame.
- bitcnt width is clog2(FRAME_BITS+1). bitcnt never exceeds FRAME_BITS and never wraps.
- rx_frame, rx_word and rx_word_idx hold their values until the next update.
- busy = state != IDLE.

Test Plan:
All scenarios use FRAME_BITS=32, WORD_BITS=8, clk = 8x sck.
1. Reset low mid-frame after 13 sample edges:
   - Required: all outputs 0 within the same clk.
   - After release, the next full frame is received correctly with no frame_err.
2. Nominal transfer, CPOL=0, tx_frame=0xA5C3_0F81, MCU sends 0x1234_5678:
   - sdo bit stream is 0xA5C3_0F81, MSB first.
   - rx_word_valid pulses 4 times, with words 0x12, 0x34, 0x56, 0x78 at idx 0..3.
   - rx_valid pulses once, rx_frame=0x1234_5678, busy falls 3 clk after cs_n rises.
3. tx_frame changes to 0xFFFF_FFFF after bit 5:
   - sdo still shifts out 0xA5C3_0F81.
   - The next frame transmits 0xFFFF_FFFF.
4. cs_n rises after 20 bits of 0xDEAD_BEEF:
   - Words 0xDE and 0xAD are pulsed.
   - frame_err pulses once, no rx_valid, rx_frame keeps the previous value 0x1234_5678.
5. 40 sck cycles in one select window:
   - rx_valid after bit 32 with the first 32 bits.
   - Bits 33-40 are ignored: no pulses, sdo=0, no frame_err when cs_n rises.
6. CPOL=1, sck idle high, MCU sends 0x0000_00FF:
   - rx_frame=0x0000_00FF.
   - Sampling occurs on falling sck, and sdo changes only on rising sck.
